commit_write_buffer: RTL and testbench
======================================

Name: commit_write_buffer

Overview:
- Parametrised commit-stage write unit for the superscalar MIPS core.
- Accepts a bundle of up to LANES retiring results per cycle, in program order with lane 0 the oldest.
- Buffers every register write in an in-order FIFO and drains up to WR_PORTS writes per cycle to the regfile.
- No write is ever dropped when lanes outnumber write ports; excess writes are serialised. Provides backpressure, flush and WAW squash within a drain group.

Parameters:
- LANES, 2, commit lanes per cycle; range 1..4.
- WR_PORTS, 1, regfile write ports; range 1..LANES.
- DEPTH, 4, FIFO entries; power of two, at least LANES.
- DATA_W, 32, result width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush  in  1  discard all buffered writes and the incoming bundle.
- in_valid  in  1  bundle present.
- in_ready  out  1  bundle can be accepted.
- req_write_need  in  LANES  per-lane write request; bit i is lane i.
- req_addr  in  LANES*ADDR_W  lane i occupies slice [i*ADDR_W +: ADDR_W].
- req_result  in  LANES*DATA_W  lane i occupies slice [i*DATA_W +: DATA_W].
- regfile_write_ena  out  WR_PORTS  per-port write enable.
- regfile_write_addr  out  WR_PORTS*ADDR_W  per-port address.
- regfile_write_data  out  WR_PORTS*DATA_W  per-port data.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: FIFO empty, pointers 0, occupancy 0, in_ready 1, all regfile_write_ena 0, write addr/data 0.
- Storage: circular FIFO of {addr, data}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- in_ready:
  - Equals (DEPTH - occupancy) >= LANES.
  - Depends on registered state only; independent of in_valid and of the current cycle's drain.
- Accept: occurs when in_valid && in_ready && !flush.
  - Each lane with write_need=1 and addr != 0 is enqueued, in lane-index order (lane 0 first).
  - Lanes with addr == 0 are discarded (r0 is never written).
  - A bundle with no qualifying lanes is accepted and enqueues nothing.
- Drain:
  - Every cycle the oldest min(occupancy, WR_PORTS) entries are presented on the ports, combinationally from the FIFO head.
  - Port p carries entry head+p. Unused ports have ena 0, addr 0, data 0.
  - All presented entries are popped at the clock edge; the regfile has no stall.
- Latency: an entry enqueued at edge t appears on the ports in the cycle after t at the earliest. There is no input-to-port bypass.
- WAW squash: if two presented entries in the same cycle share an address, the older entry's ena is forced to 0. It is still popped. Only the youngest write lands.
- Simultaneous enqueue and drain in one cycle: occupancy_next = occupancy + enq_count - deq_count.
- Flush:
  - Synchronous; priority over both accept and drain.
  - Next cycle: FIFO empty, pointers 0, ports idle.
  - Writes presented during the flush cycle are still visible on the ports that cycle, but the regfile controller must gate them with flush; this block does not gate them.
- Reset mid-operation: contents are lost immediately (asynchronous), and outputs go to their reset values in the same cycle.
- Invariants:
  - occupancy never exceeds DEPTH.
  - Writes reach the regfile in program order.
  - The oldest write is never overtaken.

Test Plan:
1. LANES=2, WR_PORTS=1: bundle {L0: r3=0x11, L1: r4=0x22} accepted at edge 0 -> cycle 1 port0 r3/0x11; cycle 2 port0 r4/0x22; cycle 3 ena=0. Both writes land; neither is dropped.
2. DEPTH=4, WR_PORTS=1: three back-to-back two-write bundles -> in_ready falls to 0 once occupancy reaches 3. Third bundle is held until occupancy <= 2. All 6 writes exit in order; occupancy never exceeds 4.
3. WR_PORTS=2: bundle {L0: r5=0xA, L1: r5=0xB} -> same cycle, port0 ena=0, port1 r5/0xB. Next cycle occupancy 0.
4. Bundle {L0: r0=0xFF, L1: r7=0x1} -> only r7 is enqueued (occupancy 1). The next cycle shows a single write r7/0x1.
5. Occupancy 3 with a valid bundle and flush=1 in the same cycle -> next cycle occupancy 0, ena=0, in_ready=1. None of the buffered or incoming writes appear afterwards.
6. rst_n asserted low mid-drain with occupancy 2 -> outputs go to 0 and occupancy to 0 asynchronously. After release, the first new bundle drains normally.

Source files
------------

// File: rtl/commit_write_buffer.sv
// commit_write_buffer: in-order FIFO between the commit lanes and the regfile write ports
// Ports: clk, rst_n (async, active-low); flush drops buffered and incoming writes;
//        in_valid/in_ready bundle handshake; req_write_need/req_addr/req_result carry
//        LANES retiring results (lane 0 oldest); regfile_write_ena/addr/data drive
//        WR_PORTS regfile ports from the FIFO head; occupancy is the live entry count.
module commit_write_buffer #(
    parameter int LANES    = 2,
    parameter int WR_PORTS = 1,
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             req_write_need,
    input  logic [LANES*ADDR_W-1:0]      req_addr,
    input  logic [LANES*DATA_W-1:0]      req_result,
    output logic [WR_PORTS-1:0]          regfile_write_ena,
    output logic [WR_PORTS*ADDR_W-1:0]   regfile_write_addr,
    output logic [WR_PORTS*DATA_W-1:0]   regfile_write_data,
    output logic [$clog2(DEPTH):0]       occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [OW-1:0]     occ, enq_cnt, deq_cnt;
    logic [LANES-1:0]  lane_ok;
    logic [PW-1:0]     lane_slot [LANES];
    logic              accept;

    assign occupancy = occ;
    assign in_ready  = (OW'(DEPTH) - occ) >= OW'(LANES);
    assign accept    = in_valid && in_ready && !flush;
    assign deq_cnt   = occ < OW'(WR_PORTS) ? occ : OW'(WR_PORTS);

    // qualifying lanes are packed densely behind wr_ptr in lane order
    always_comb begin
        enq_cnt   = '0;
        lane_ok   = '0;
        lane_slot = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            lane_ok[i]   = accept && req_write_need[i] && req_addr[i*ADDR_W +: ADDR_W] != '0;
            lane_slot[i] = wr_ptr + enq_cnt[PW-1:0];
            enq_cnt      = enq_cnt + OW'(lane_ok[i]);
        end
    end

    // an older presented write is masked when a younger presented one hits the same register
    always_comb begin
        regfile_write_ena  = '0;
        regfile_write_addr = '0;
        regfile_write_data = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            regfile_write_ena[p] = OW'(p) < deq_cnt;
            for (int q = p + 1; q < WR_PORTS; q++)
                if (OW'(q) < deq_cnt && addr_mem[rd_ptr + PW'(q)] == addr_mem[rd_ptr + PW'(p)])
                    regfile_write_ena[p] = 1'b0;
            regfile_write_addr[p*ADDR_W +: ADDR_W] = OW'(p) < deq_cnt ? addr_mem[rd_ptr + PW'(p)] : '0;
            regfile_write_data[p*DATA_W +: DATA_W] = OW'(p) < deq_cnt ? data_mem[rd_ptr + PW'(p)] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr + deq_cnt[PW-1:0];
            wr_ptr <= wr_ptr + enq_cnt[PW-1:0];
            occ    <= occ + enq_cnt - deq_cnt;
        end
    end

    // storage needs no reset: ports are gated by occupancy
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (lane_ok[i]) begin
                addr_mem[lane_slot[i]] <= req_addr[i*ADDR_W +: ADDR_W];
                data_mem[lane_slot[i]] <= req_result[i*DATA_W +: DATA_W];
            end
    end
endmodule

// File: tb/tb_commit_write_buffer.sv
// tb_commit_write_buffer: vector table plus scoreboard bench for commit_write_buffer
module tb_commit_write_buffer;
    localparam int L  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_valid2 = 1'b0;
    logic [L-1:0]    need = '0;
    logic [L*AW-1:0] addr = '0;
    logic [L*DW-1:0] res  = '0;
    logic            rdy1, rdy2;
    logic [0:0]      ena1;
    logic [AW-1:0]   wa1;
    logic [DW-1:0]   wd1;
    logic [1:0]      ena2;
    logic [2*AW-1:0] wa2;
    logic [2*DW-1:0] wd2;
    logic [2:0]      occ1, occ2;
    int pass_cnt = 0, total = 0, m_occ = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { logic [1:0] need; logic [AW-1:0] a0, a1; logic [DW-1:0] d0, d1;
                     int n; logic [AW-1:0] ea; logic [DW-1:0] ed; } vec_t;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t tbl[7];

    always #5 clk = ~clk;

    commit_write_buffer #(.LANES(2), .WR_PORTS(1), .DEPTH(4), .DATA_W(DW), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .req_write_need(need), .req_addr(addr), .req_result(res),
        .regfile_write_ena(ena1), .regfile_write_addr(wa1), .regfile_write_data(wd1),
        .occupancy(occ1));

    commit_write_buffer #(.LANES(2), .WR_PORTS(2), .DEPTH(4), .DATA_W(DW), .ADDR_W(AW)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid2), .in_ready(rdy2),
        .req_write_need(need), .req_addr(addr), .req_result(res),
        .regfile_write_ena(ena2), .regfile_write_addr(wa2), .regfile_write_data(wd2),
        .occupancy(occ2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // every write leaving dut1 must be the oldest outstanding expected write
    always @(negedge clk) begin
        if (rst_n && !flush && ena1[0]) begin
            total++;
            if (exp_q.size() == 0)
                $display("FAIL drain: unexpected write r%0d=%0h", wa1, wd1);
            else begin
                mon_e = exp_q.pop_front();
                if (mon_e.a === wa1 && mon_e.d === wd1) pass_cnt++;
                else $display("FAIL drain: got r%0d=%0h expected r%0d=%0h", wa1, wd1, mon_e.a, mon_e.d);
            end
        end
    end

    // one clock of dut1 against a reference occupancy model; pushes accepted writes
    task automatic cyc();
        int  enq = 0;
        logic mr, acc;
        mr  = (4 - m_occ) >= 2;
        chk("in_ready", 64'(rdy1), 64'(mr));
        chk("occupancy", 64'(occ1), 64'(m_occ));
        acc = in_valid && mr && !flush;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            m_occ = 0;
        end else begin
            if (acc)
                for (int i = 0; i < L; i++)
                    if (need[i] && addr[i*AW +: AW] != '0) begin
                        exp_q.push_back('{addr[i*AW +: AW], res[i*DW +: DW]});
                        enq++;
                    end
            m_occ = m_occ + enq - (m_occ > 0 ? 1 : 0);
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && m_occ > 0; k++) cyc();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_ena", 64'(ena1), 64'd0);
    endtask

    task automatic bundle(input logic [1:0] n, input logic [AW-1:0] a0, a1, input logic [DW-1:0] d0, d1);
        need = n;
        addr = {a1, a0};
        res  = {d1, d0};
    endtask

    initial begin
        tbl[0] = '{2'b11, 5'd3,  5'd4,  32'h11, 32'h22, 2, 5'd3,  32'h11};
        tbl[1] = '{2'b11, 5'd0,  5'd7,  32'hFF, 32'h01, 1, 5'd7,  32'h01};
        tbl[2] = '{2'b01, 5'd9,  5'd10, 32'h33, 32'h44, 1, 5'd9,  32'h33};
        tbl[3] = '{2'b10, 5'd1,  5'd31, 32'h55, 32'h66, 1, 5'd31, 32'h66};
        tbl[4] = '{2'b00, 5'd2,  5'd3,  32'h77, 32'h88, 0, 5'd0,  32'h0};
        tbl[5] = '{2'b11, 5'd0,  5'd0,  32'h99, 32'hAA, 0, 5'd0,  32'h0};
        tbl[6] = '{2'b11, 5'd6,  5'd6,  32'hAA, 32'hBB, 2, 5'd6,  32'hAA};

        #12;
        chk("rst_occ1", 64'(occ1), 64'd0);
        chk("rst_ready1", 64'(rdy1), 64'd1);
        chk("rst_port1", {31'(ena1), wa1, wd1}, 64'd0);
        chk("rst_ena2", 64'(ena2), 64'd0);
        chk("rst_port2", {wa2, wd2}, 74'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WAW squash on the two-port instance
        bundle(2'b11, 5'd5, 5'd5, 32'hA, 32'hB);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("waw_occ", 64'(occ2), 64'd2);
        chk("waw_ena", 64'(ena2), 64'b10);
        chk("waw_p1", {wa2[2*AW-1:AW], wd2[2*DW-1:DW]}, {5'd5, 32'hB});
        @(posedge clk); #1;
        chk("waw_occ_after", 64'(occ2), 64'd0);
        chk("waw_ena_after", 64'(ena2), 64'd0);
        bundle(2'b11, 5'd8, 5'd9, 32'hC, 32'hD);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("dual_ena", 64'(ena2), 64'b11);
        chk("dual_addr", 64'(wa2), {5'd9, 5'd8});
        chk("dual_data", wd2, {32'hD, 32'hC});
        @(posedge clk); #1;
        chk("dual_ena_after", 64'(ena2), 64'd0);

        // table of single bundles into the one-port instance
        for (int k = 0; k < 7; k++) begin
            bundle(tbl[k].need, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1);
            in_valid = 1'b1;
            cyc();
            in_valid = 1'b0;
            chk($sformatf("v%0d_occ", k), 64'(occ1), 64'(tbl[k].n));
            chk($sformatf("v%0d_ena", k), 64'(ena1), 64'(tbl[k].n > 0));
            chk($sformatf("v%0d_head", k), {wa1, wd1}, {tbl[k].ea, tbl[k].ed});
            drain();
        end

        // three back-to-back bundles against DEPTH=4 with one port
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bundle(2'b11, AW'(2 * b + 1), AW'(2 * b + 2), DW'(b * 16 + 1), DW'(b * 16 + 2));
            for (int t = 0; t < 10; t++) begin
                logic took;
                took = (4 - m_occ) >= 2;
                cyc();
                if (took) break;
            end
        end
        in_valid = 1'b0;
        drain();

        // flush with occupancy 3 and an incoming bundle
        in_valid = 1'b1;
        bundle(2'b11, 5'd1, 5'd2, 32'h101, 32'h102);
        cyc();
        bundle(2'b11, 5'd3, 5'd4, 32'h103, 32'h104);
        cyc();
        chk("pre_flush_occ", 64'(occ1), 64'd3);
        bundle(2'b11, 5'd5, 5'd6, 32'h105, 32'h106);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occ1), 64'd0);
        chk("flush_ena", 64'(ena1), 64'd0);
        chk("flush_ready", 64'(rdy1), 64'd1);
        for (int k = 0; k < 4; k++) cyc();

        // asynchronous reset mid-drain
        in_valid = 1'b1;
        bundle(2'b11, 5'd11, 5'd12, 32'h211, 32'h212);
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_occ", 64'(occ1), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_occ", 64'(occ1), 64'd0);
        chk("arst_port", {31'(ena1), wa1, wd1}, 64'd0);
        chk("arst_ready", 64'(rdy1), 64'd1);
        exp_q.delete();
        m_occ = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        bundle(2'b11, 5'd13, 5'd14, 32'h313, 32'h314);
        cyc();
        in_valid = 1'b0;
        chk("post_rst_head", {wa1, wd1}, {5'd13, 32'h313});
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
